neuron_layer_driver: RTL and testbench
======================================

// Module: neuron_layer_driver
// PURPOSE
//   Initiator side of the neuron-layer req/ack MAC interface. Accepts an input
//   vector as a valid/ready stream and writes it into the layer's input RAM.
//   Issues a one-cycle req, waits for ack, and captures the per-neuron
//   accumulators. Emits the results one neuron per beat on an output stream.
//   Sits between the sample source and the neuron layer (or the next layer's loader).
// PARAMETERS
//   N_IN     2    input vector length (input RAM depth), >=1
//   N_OUT    2    neurons in the layer (accumulator count), >=1
//   DW       8    data / accumulator width, two's complement
//   TIMEOUT  255  max cycles in WAIT before abort, >=1
// PORTS
//   clk      in   1           clock, all logic on posedge
//   rst      in   1           synchronous reset, active-high
//   s_valid  in   1           input sample valid
//   s_ready  out  1           input sample accepted when s_valid&s_ready
//   s_data   in   DW          input sample
//   wr_en    out  1           input RAM write strobe
//   wr_addr  out  AW          input RAM address, AW=max(1,$clog2(N_IN))
//   wr_data  out  DW          input RAM write data
//   req      out  1           start pulse to layer
//   ack      in   1           layer done; acc_i valid in the same cycle
//   acc_i    in   N_OUT*DW    accumulators, neuron k at [k*DW +: DW]
//   m_valid  out  1           result valid
//   m_ready  in   1           result accepted when m_valid&m_ready
//   m_data   out  DW          result for neuron m_idx
//   m_idx    out  OW          neuron index, OW=max(1,$clog2(N_OUT))
//   busy     out  1           high in any state except IDLE with cnt==0
//   err_timeout out 1         sticky: a WAIT timed out; cleared only by rst
// BEHAVIOUR
//   Reset: state=IDLE; counters 0; s_ready=0 during rst, else 1 in IDLE;
//     wr_en=0, wr_addr=0, wr_data=0, req=0, m_valid=0, m_data=0, m_idx=0,
//     busy=0, err_timeout=0. Reset mid-operation aborts with no partial output.
//   States: IDLE -> REQ -> WAIT -> EMIT -> IDLE.
//   IDLE: s_ready=1. Each accepted beat registers wr_en=1, wr_addr=cnt,
//     wr_data=s_data (1-cycle write latency), cnt++. When beat N_IN-1 is
//     accepted: cnt=0, next state REQ. wr_en is 0 on cycles with no accept.
//   REQ: req=1 for exactly one cycle (layer holds its own run flag); s_ready=0;
//     -> WAIT. The last RAM write and req are never in the same cycle.
//   WAIT: tmo counts from 0. ack=1 -> capture all N_OUT accumulators into
//     result regs, -> EMIT (ack sampled only in WAIT; ack in any other
//     state ignored). ack and tmo==TIMEOUT in the same cycle: ack wins.
//     tmo==TIMEOUT without ack -> err_timeout=1, results discarded, -> IDLE.
//   EMIT: m_valid=1, m_data=res[idx], m_idx=idx, all registered outputs.
//     On m_valid&m_ready: idx++; on idx==N_OUT-1 accepted -> m_valid=0 next
//     cycle, idx=0, -> IDLE. m_valid/m_data stable while m_ready=0.
//   Minimum latency: last input accept -> req 1 cycle; ack -> m_valid 1 cycle.
//   Arithmetic: acc_i captured at DW, no widening; counters wrap never
//     (bounded by N_IN-1, N_OUT-1, TIMEOUT).
// CONFIGURATION
//   NEURON_LAYER_DRIVER_RELU_EN defined: at capture each result is
//     (acc[DW-1] ? 0 : acc) (ReLU on signed value).
//   Not defined: results captured raw, bit-exact to acc_i.
// TESTING
//   T1 rst=1 2 cycles -> all outputs 0, state IDLE; rst=0 -> s_ready=1.
//   T2 N_IN=2: send 3,5 back-to-back -> wr (0,3),(1,5); req pulse exactly 1
//      cycle, 1 cycle after second accept.
//   T3 ack 4 cycles after req with acc_i={8'h10,8'h0C} -> m (idx0,0x0C),
//      (idx1,0x10) with m_ready=1; back to IDLE, s_ready=1.
//   T4 m_ready=0 for 5 cycles in EMIT -> m_valid held, m_data stable,
//      no index advance; then release -> both beats emitted in order.
//   T5 no ack, TIMEOUT=8 -> err_timeout=1 after 9 WAIT cycles, no m_valid,
//      IDLE; later ack ignored; next vector runs normally, flag stays 1.
//   T6 acc_i={8'hF0,8'h07}: RELU_EN -> 0x07,0x00; without -> 0x07,0xF0;
//      rst asserted mid-EMIT -> m_valid=0 next cycle.

Source files
------------

// File: rtl/neuron_layer_driver.sv
// Initiator for the neuron-layer req/ack MAC interface: streams an input vector into the
// layer RAM, pulses req, captures accumulators on ack, then streams them out one per beat.
// Optional: define NEURON_LAYER_DRIVER_RELU_EN to clamp negative accumulators to 0 at capture.
module neuron_layer_driver #(
  parameter int N_IN    = 2,
  parameter int N_OUT   = 2,
  parameter int DW      = 8,
  parameter int TIMEOUT = 255,
  localparam int AW = (N_IN  > 1) ? $clog2(N_IN)  : 1,
  localparam int OW = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DW-1:0]       s_data,
  output logic                wr_en,
  output logic [AW-1:0]       wr_addr,
  output logic [DW-1:0]       wr_data,
  output logic                req,
  input  logic                ack,
  input  logic [N_OUT*DW-1:0] acc_i,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DW-1:0]       m_data,
  output logic [OW-1:0]       m_idx,
  output logic                busy,
  output logic                err_timeout
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_EMIT = 2'd3;

  localparam logic [AW-1:0] CNT_LAST = AW'(N_IN - 1);
  localparam logic [OW-1:0] IDX_LAST = OW'(N_OUT - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic          req_q, req_d;
  logic          m_valid_q, m_valid_d;
  logic [DW-1:0] m_data_q, m_data_d;
  logic [OW-1:0] m_idx_q, m_idx_d;
  logic          err_q, err_d;
  logic [DW-1:0] res_q [N_OUT];
  logic [DW-1:0] res_d [N_OUT];
  logic [DW-1:0] acc_cap [N_OUT];
  logic [OW-1:0] idx_inc;

  // Value each neuron's accumulator takes when captured on ack.
  generate
    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_cap
`ifdef NEURON_LAYER_DRIVER_RELU_EN
      assign acc_cap[gi] = acc_i[gi*DW + DW - 1] ? '0 : acc_i[gi*DW +: DW];
`else
      assign acc_cap[gi] = acc_i[gi*DW +: DW];
`endif
    end
  endgenerate

  assign idx_inc = m_idx_q + OW'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    req_d     = 1'b0;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_idx_d   = m_idx_q;
    err_d     = err_q;
    res_d     = res_q;
    case (state_q)
      S_IDLE: begin
        if (s_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q;
          wr_data_d = s_data;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = S_REQ;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      // req is registered, so it appears one cycle after the final RAM write.
      S_REQ: begin
        req_d   = 1'b1;
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ack) begin
          res_d     = acc_cap;
          m_valid_d = 1'b1;
          m_data_d  = acc_cap[0];
          m_idx_d   = '0;
          tmo_d     = '0;
          state_d   = S_EMIT;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          tmo_d   = '0;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_EMIT: begin
        if (m_ready) begin
          if (m_idx_q == IDX_LAST) begin
            m_valid_d = 1'b0;
            m_data_d  = '0;
            m_idx_d   = '0;
            state_d   = S_IDLE;
          end else begin
            m_idx_d  = idx_inc;
            m_data_d = res_q[idx_inc];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      tmo_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      req_q     <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_idx_q   <= '0;
      err_q     <= 1'b0;
      for (int k = 0; k < N_OUT; k++) res_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      req_q     <= req_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_idx_q   <= m_idx_d;
      err_q     <= err_d;
      res_q     <= res_d;
    end
  end

  assign s_ready     = (state_q == S_IDLE) && !rst;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign req         = req_q;
  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign m_idx       = m_idx_q;
  assign err_timeout = err_q;
  assign busy        = !((state_q == S_IDLE) && (cnt_q == '0));

endmodule

// File: tb/tb_neuron_layer_driver.sv
// Directed bench for neuron_layer_driver (N_IN=2, N_OUT=2, DW=8, TIMEOUT=8).
// Inputs change and outputs are checked on the falling clock edge.
module tb_neuron_layer_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        wr_en;
  logic [0:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        req;
  logic        ack;
  logic [15:0] acc_i;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic [0:0]  m_idx;
  logic        busy;
  logic        err_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  neuron_layer_driver #(.N_IN(2), .N_OUT(2), .DW(8), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .req(req), .ack(ack),
    .acc_i(acc_i), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_idx(m_idx), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && wr_en) $display("wr   addr=%0d data=%h", wr_addr, wr_data);
    if (!rst && m_valid && m_ready) $display("out  idx=%0d data=%h", m_idx, m_data);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Drives two beats back-to-back; returns in the cycle after the last accept (REQ state).
  task automatic send_vec(input logic [7:0] a, input logic [7:0] b);
    s_valid = 1'b1; s_data = a;
    @(negedge clk);
    s_data = b;
    @(negedge clk);
    s_valid = 1'b0; s_data = 8'h00;
  endtask

  task automatic test_reset;
    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; ack = 1'b0; acc_i = 16'h0000; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL rst_s_ready: got %b expected 0", s_ready); end
    n_checks++; if ({wr_en, wr_addr, wr_data} !== 10'h000) begin n_fail++; $display("FAIL rst_wr: got %h expected 000", {wr_en, wr_addr, wr_data}); end
    n_checks++; if ({req, m_valid, m_data, m_idx} !== 11'h000) begin n_fail++; $display("FAIL rst_out: got %h expected 000", {req, m_valid, m_data, m_idx}); end
    n_checks++; if ({busy, err_timeout} !== 2'b00) begin n_fail++; $display("FAIL rst_busy_err: got %b expected 00", {busy, err_timeout}); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_s_ready: got %b expected 1", s_ready); end
    $display("reset done");
  endtask

  task automatic test_write_req;
    s_valid = 1'b1; s_data = 8'h03;
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL t2_ready0: got %b expected 1", s_ready); end
    @(negedge clk);
    n_checks++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 1'b0, 8'h03}) begin n_fail++; $display("FAIL t2_wr0: got %h expected %h", {wr_en, wr_addr, wr_data}, {1'b1, 1'b0, 8'h03}); end
    n_checks++; if ({busy, s_ready} !== 2'b11) begin n_fail++; $display("FAIL t2_busy_ready1: got %b expected 11", {busy, s_ready}); end
    s_data = 8'h05;
    @(negedge clk);
    s_valid = 1'b0;
    n_checks++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 1'b1, 8'h05}) begin n_fail++; $display("FAIL t2_wr1: got %h expected %h", {wr_en, wr_addr, wr_data}, {1'b1, 1'b1, 8'h05}); end
    n_checks++; if ({req, s_ready} !== 2'b00) begin n_fail++; $display("FAIL t2_no_req_with_write: got %b expected 00", {req, s_ready}); end
    @(negedge clk);
    n_checks++; if ({req, wr_en} !== 2'b10) begin n_fail++; $display("FAIL t2_req_pulse: got %b expected 10", {req, wr_en}); end
    $display("req issued");
  endtask

  task automatic test_ack_emit;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      n_checks++; if ({req, m_valid, busy} !== 3'b001) begin n_fail++; $display("FAIL t3_wait%0d: got %b expected 001", i, {req, m_valid, busy}); end
    end
    @(negedge clk);
    ack = 1'b1; acc_i = 16'h100C; m_ready = 1'b1;
    @(negedge clk);
    ack = 1'b0; acc_i = 16'hAAAA;
    n_checks++; if ({m_valid, m_idx, m_data} !== {1'b1, 1'b0, 8'h0C}) begin n_fail++; $display("FAIL t3_beat0: got %h expected %h", {m_valid, m_idx, m_data}, {1'b1, 1'b0, 8'h0C}); end
    @(negedge clk);
    n_checks++; if ({m_valid, m_idx, m_data} !== {1'b1, 1'b1, 8'h10}) begin n_fail++; $display("FAIL t3_beat1: got %h expected %h", {m_valid, m_idx, m_data}, {1'b1, 1'b1, 8'h10}); end
    @(negedge clk);
    m_ready = 1'b0;
    n_checks++; if ({m_valid, s_ready, busy} !== 3'b010) begin n_fail++; $display("FAIL t3_idle: got %b expected 010", {m_valid, s_ready, busy}); end
  endtask

  task automatic test_backpressure;
    send_vec(8'h01, 8'h02);
    @(negedge clk);
    ack = 1'b1; acc_i = 16'h2211;
    @(negedge clk);
    ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if ({m_valid, m_idx, m_data} !== {1'b1, 1'b0, 8'h11}) begin n_fail++; $display("FAIL t4_hold%0d: got %h expected %h", i, {m_valid, m_idx, m_data}, {1'b1, 1'b0, 8'h11}); end
      if (i < 4) @(negedge clk);
    end
    m_ready = 1'b1;
    @(negedge clk);
    n_checks++; if ({m_valid, m_idx, m_data} !== {1'b1, 1'b1, 8'h22}) begin n_fail++; $display("FAIL t4_beat1: got %h expected %h", {m_valid, m_idx, m_data}, {1'b1, 1'b1, 8'h22}); end
    @(negedge clk);
    m_ready = 1'b0;
    n_checks++; if ({m_valid, s_ready} !== 2'b01) begin n_fail++; $display("FAIL t4_idle: got %b expected 01", {m_valid, s_ready}); end
  endtask

  task automatic test_timeout;
    logic [7:0] exp_hi;
    send_vec(8'h04, 8'h06);
    @(negedge clk);
    // First WAIT cycle is the req cycle; tmo reaches 8 on the ninth.
    for (int i = 0; i < 9; i++) begin
      n_checks++; if ({m_valid, err_timeout, busy} !== 3'b001) begin n_fail++; $display("FAIL t5_wait%0d: got %b expected 001", i, {m_valid, err_timeout, busy}); end
      @(negedge clk);
    end
    n_checks++; if ({err_timeout, s_ready, busy, m_valid} !== 4'b1100) begin n_fail++; $display("FAIL t5_abort: got %b expected 1100", {err_timeout, s_ready, busy, m_valid}); end
    $display("timeout flagged");
    ack = 1'b1; acc_i = 16'h5555;
    @(negedge clk);
    ack = 1'b0;
    n_checks++; if ({m_valid, s_ready} !== 2'b01) begin n_fail++; $display("FAIL t5_late_ack: got %b expected 01", {m_valid, s_ready}); end
    send_vec(8'h07, 8'h08);
    @(negedge clk);
    @(negedge clk);
    ack = 1'b1; acc_i = 16'hF007; m_ready = 1'b1;
    @(negedge clk);
    ack = 1'b0;
`ifdef NEURON_LAYER_DRIVER_RELU_EN
    exp_hi = 8'h00;
`else
    exp_hi = 8'hF0;
`endif
    n_checks++; if ({m_valid, m_idx, m_data} !== {1'b1, 1'b0, 8'h07}) begin n_fail++; $display("FAIL t6_beat0: got %h expected %h", {m_valid, m_idx, m_data}, {1'b1, 1'b0, 8'h07}); end
    @(negedge clk);
    n_checks++; if ({m_valid, m_idx, m_data} !== {1'b1, 1'b1, exp_hi}) begin n_fail++; $display("FAIL t6_beat1: got %h expected %h", {m_valid, m_idx, m_data}, {1'b1, 1'b1, exp_hi}); end
    n_checks++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL t5_sticky: got %b expected 1", err_timeout); end
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  task automatic test_reset_mid_emit;
    send_vec(8'h09, 8'h0A);
    @(negedge clk);
    ack = 1'b1; acc_i = 16'h3344;
    @(negedge clk);
    ack = 1'b0;
    n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL t6_emit_before_rst: got %b expected 1", m_valid); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if ({m_valid, m_data, s_ready, err_timeout, busy} !== 12'h000) begin n_fail++; $display("FAIL t6_rst_mid_emit: got %h expected 000", {m_valid, m_data, s_ready, err_timeout, busy}); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if ({m_valid, s_ready} !== 2'b01) begin n_fail++; $display("FAIL t6_after_rst: got %b expected 01", {m_valid, s_ready}); end
  endtask

  initial begin
    test_reset();
    test_write_req();
    test_ack_emit();
    test_backpressure();
    test_timeout();
    test_reset_mid_emit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
